// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiplier controller.
//   state_t    : controller states (idle, issuing partial products, result held)
//   step_t     : partial-product step counter (four steps, 2 bits)
//   step_shift : left shift applied to the partial product of each step
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned STEP_W = 2;

  typedef logic [STEP_W-1:0] step_t;

  localparam step_t LAST_STEP = 2'd3;

  // step0 lo*lo -> 0, step1/step2 cross terms -> w, step3 hi*hi -> 2w
  function automatic int unsigned step_shift(input step_t step, input int unsigned w);
    case (step)
      2'd0:    return 0;
      2'd1,
      2'd2:    return w;
      default: return 2 * w;
    endcase
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_mult4.sv
// Shared W x W unsigned multiplier (team mult4 block), purely combinational.
//   x, y : W-bit unsigned operands
//   z    : 2W-bit product
module mult4 #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] z
);

  assign z = {{W{1'b0}}, x} * {{W{1'b0}}, y};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle 2W x 2W unsigned multiplier built on one shared W x W multiplier.
// Four partial products are issued one per clock and summed into a 4W accumulator;
// the product is returned over a valid/ready handshake.
//   clk       : clock, all state updates on posedge
//   rst       : asynchronous active-low reset
//   in_valid  : operands a,b presented          in_ready  : operands accepted this cycle
//   a, b      : 2W-bit unsigned operands
//   out_valid : p holds a completed product     out_ready : consumer takes p this cycle
//   p         : 4W-bit product
//   busy      : partial products being issued
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] p,
  output logic           busy
);

  state_t         state, state_nxt;
  step_t          step;
  logic [2*W-1:0] a_q, b_q;
  logic [4*W-1:0] acc;
  logic           accept;

  logic [W-1:0]   mx, my;
  logic [2*W-1:0] pp;
  logic [4*W-1:0] pp_sh;
  logic [4*W-1:0] acc_sum;

  // step bit0 selects the high half of a, bit1 the high half of b
  assign mx = step[0] ? a_q[2*W-1:W] : a_q[W-1:0];
  assign my = step[1] ? b_q[2*W-1:W] : b_q[W-1:0];

  mult4 #(.W(W)) u_mult (
    .x (mx),
    .y (my),
    .z (pp)
  );

  assign pp_sh   = {{(2*W){1'b0}}, pp} << step_shift(step, W);
  assign acc_sum = acc + pp_sh;

  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    accept    = in_valid && in_ready;
    busy      = (state == S_MUL);
    out_valid = (state == S_DONE);
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_MUL;
      S_MUL:  if (step == LAST_STEP) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = in_valid ? S_MUL : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      step <= '0;
      p    <= '0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      step <= '0;
    end else if (state == S_MUL) begin
      acc  <= acc_sum;
      step <= step + 1'b1;
      if (step == LAST_STEP) p <= acc_sum;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mult_seq_ctrl #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] vp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int unsigned r;
    r = int'(x) * int'(y);
    return r[15:0];
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation from IDLE with out_ready held high.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2, input logic [15:0] exp);
    a = ta; b = tb2; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("idle_in_ready", in_ready, 1);
    step_clk();
    in_valid = 1'b0; a = ~ta; b = ~tb2;
    for (int i = 0; i < 4; i++) begin
      check("busy_during_mul", busy, 1);
      check("no_valid_during_mul", out_valid, 0);
      step_clk();
    end
    check("valid_at_lat4", out_valid, 1);
    check("busy_low_done", busy, 0);
    check("product", p, exp);
    check("done_in_ready", in_ready, 1);
    step_clk();
    check("valid_cleared", out_valid, 0);
    check("p_holds", p, exp);
  endtask

  // Randomised stream against a queue scoreboard; pv/pr are percent chances.
  task automatic run_stream(input int unsigned n, input int unsigned pv,
                            input int unsigned pr, input bit b2b);
    logic [15:0] expq[$];
    int          acq[$];
    int unsigned sent = 0, got = 0;
    int          cyc = 0, last_rise = -1;
    bit          shown = 1'b0, hs_in, hs_out;
    logic [15:0] cur_p;
    in_valid  = ($urandom_range(99) < pv);
    a         = 8'($urandom);
    b         = 8'($urandom);
    out_ready = ($urandom_range(99) < pr);
    while (got < n && cyc < 20000) begin
      @(negedge clk);
      if (out_valid && !shown) begin
        shown = 1'b1;
        if (acq.size() == 0) check("spurious_valid", 1, 0);
        else check("stream_latency", 32'(cyc - acq[0]), 4);
        if (b2b && last_rise >= 0) check("b2b_interval", 32'(cyc - last_rise), 5);
        last_rise = cyc;
      end
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      cur_p  = p;
      step_clk();
      cyc++;
      if (hs_out) begin
        if (expq.size() == 0) check("unexpected_output", 1, 0);
        else begin
          check("stream_product", cur_p, expq.pop_front());
          void'(acq.pop_front());
        end
        got++;
        shown = 1'b0;
      end
      if (hs_in) begin
        expq.push_back(ref_mul(a, b));
        acq.push_back(cyc);
        sent++;
      end
      if (hs_in || !in_valid) begin
        in_valid = (sent < n) && ($urandom_range(99) < pv);
        a = 8'($urandom);
        b = 8'($urandom);
      end
      out_ready = ($urandom_range(99) < pr);
    end
    check("stream_completed", got, n);
    check("stream_queue_empty", expq.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step_clk();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h12, 8'h34, 16'h03A8};
    vecs[2] = '{8'h00, 8'hA5, 16'h0000};
    vecs[3] = '{8'h03, 8'h05, 16'h000F};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[6] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[7] = '{8'h0F, 8'hF0, 16'h0E10};
    vecs[8] = '{8'hF0, 8'h0F, 16'h0E10};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p", p, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    step_clk();

    for (int i = 0; i < 9; i++) run_op(vecs[i].va, vecs[i].vb, vecs[i].vp);

    // Backpressure: result held three cycles while extra operands are offered.
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    step_clk();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    step_clk();
    check("bp_valid", out_valid, 1);
    check("bp_p", p, 16'hFE01);
    in_valid = 1'b1; a = 8'h09; b = 8'h09;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready_low", in_ready, 0);
      check("bp_valid_hold", out_valid, 1);
      check("bp_p_hold", p, 16'hFE01);
      check("bp_busy_low", busy, 0);
      step_clk();
    end
    out_ready = 1'b1; a = 8'h03; b = 8'h05;
    #1 check("bp_release_in_ready", in_ready, 1);
    step_clk();
    in_valid = 1'b0;
    check("bp_reaccept_busy", busy, 1);
    check("bp_reaccept_valid", out_valid, 0);
    check("bp_p_until_next", p, 16'hFE01);
    repeat (3) step_clk();
    check("bp_next_not_yet", out_valid, 0);
    step_clk();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_p", p, 16'h000F);
    step_clk();

    // Reset during step2.
    a = 8'hC3; b = 8'h7E; in_valid = 1'b1; out_ready = 1'b1;
    step_clk();
    in_valid = 1'b0;
    step_clk();
    step_clk();
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_p", p, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    step_clk();
    rst = 1'b1;
    step_clk();
    run_op(8'h02, 8'h03, 16'h0006);

    // Back-to-back, then random gaps.
    run_stream(4, 100, 100, 1'b1);
    run_stream(500, 60, 60, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
